// File: rtl/edge_evt_pkg.sv
// Shared constants and types for the edge-event arbiter.
package edge_evt_pkg;

  localparam int unsigned NUM_CH_DEF = 4;

  typedef enum logic {
    EDGE_RISE = 1'b0,
    EDGE_FALL = 1'b1
  } edge_t;

endpackage

// File: rtl/edge_evt_ch.sv
// One monitored channel: edge detect, pending rise/fall flags and sticky overflow.
module edge_evt_ch
  import edge_evt_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic rise_en,
  input  logic fall_en,
  input  logic load,
  input  logic ovf_clr,
  output logic pend_rise,
  output logic pend_fall,
  output logic ovf
);

  logic prev;
  logic rise_det;
  logic fall_det;
  logic ovf_set;

  assign rise_det = a & ~prev & rise_en;
  assign fall_det = ~a & prev & fall_en;
  // A repeated edge with its flag still set is merged; loading this cycle frees the flag.
  assign ovf_set  = ((rise_det & pend_rise) | (fall_det & pend_fall)) & ~load;

  always_ff @(posedge clk) begin
    prev <= a;
    if (!rst) begin
      pend_rise <= 1'b0;
      pend_fall <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      pend_rise <= rise_det | (pend_rise & ~load);
      pend_fall <= fall_det | (pend_fall & ~load);
      ovf       <= ovf_set | (ovf & ~ovf_clr);
    end
  end

endmodule

// File: rtl/edge_event_arbiter.sv
// Multi-channel edge-event controller with a round-robin shared valid/ready event port.
module edge_event_arbiter
  import edge_evt_pkg::*;
#(
  parameter int unsigned NUM_CH = NUM_CH_DEF,
  localparam int unsigned CH_W  = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] a_i,
  input  logic [NUM_CH-1:0] cfg_rise_en_i,
  input  logic [NUM_CH-1:0] cfg_fall_en_i,
  output logic              evt_valid_o,
  input  logic              evt_ready_i,
  output logic [CH_W-1:0]   evt_ch_o,
  output logic              evt_rise_o,
  output logic              evt_fall_o,
  output logic [NUM_CH-1:0] ovf_o,
  input  logic              ovf_clr_i
);

  logic [NUM_CH-1:0] pend_rise;
  logic [NUM_CH-1:0] pend_fall;
  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] load;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   grant;
  logic              found;
  logic              slot_free;
  logic              do_load;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    edge_evt_ch u_ch (
      .clk       (clk),
      .rst       (rst),
      .a         (a_i[i]),
      .rise_en   (cfg_rise_en_i[i]),
      .fall_en   (cfg_fall_en_i[i]),
      .load      (load[i]),
      .ovf_clr   (ovf_clr_i),
      .pend_rise (pend_rise[i]),
      .pend_fall (pend_fall[i]),
      .ovf       (ovf_o[i])
    );
  end

  assign pend      = pend_rise | pend_fall;
  assign slot_free = ~evt_valid_o | evt_ready_i;
  assign do_load   = slot_free & found;

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    int idx;
    found = 1'b0;
    grant = '0;
    idx   = 0;
    for (int k = 1; k <= int'(NUM_CH); k++) begin
      idx = (int'(rr_ptr) + k) % int'(NUM_CH);
      if (!found && pend[idx]) begin
        found = 1'b1;
        grant = CH_W'(idx);
      end
    end
  end

  always_comb begin
    load = '0;
    if (do_load) load[grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      evt_valid_o <= 1'b0;
      evt_ch_o    <= '0;
      evt_rise_o  <= 1'b0;
      evt_fall_o  <= 1'b0;
      rr_ptr      <= CH_W'(NUM_CH - 1);
    end else if (do_load) begin
      evt_valid_o <= 1'b1;
      evt_ch_o    <= grant;
      evt_rise_o  <= pend_rise[grant];
      evt_fall_o  <= pend_fall[grant];
      rr_ptr      <= grant;
    end else if (slot_free) begin
      evt_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed self-checking bench for edge_event_arbiter (NUM_CH = 4).
module tb_edge_event_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a_i;
  logic [3:0] cfg_rise_en_i;
  logic [3:0] cfg_fall_en_i;
  logic       evt_valid_o;
  logic       evt_ready_i;
  logic [1:0] evt_ch_o;
  logic       evt_rise_o;
  logic       evt_fall_o;
  logic [3:0] ovf_o;
  logic       ovf_clr_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  edge_event_arbiter #(.NUM_CH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .a_i           (a_i),
    .cfg_rise_en_i (cfg_rise_en_i),
    .cfg_fall_en_i (cfg_fall_en_i),
    .evt_valid_o   (evt_valid_o),
    .evt_ready_i   (evt_ready_i),
    .evt_ch_o      (evt_ch_o),
    .evt_rise_o    (evt_rise_o),
    .evt_fall_o    (evt_fall_o),
    .ovf_o         (ovf_o),
    .ovf_clr_i     (ovf_clr_i)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_evt(input string tag, input logic v, input logic [1:0] ch,
                         input logic r, input logic f);
    chk({tag, ".valid"}, 32'(evt_valid_o), 32'(v));
    if (v) begin
      chk({tag, ".ch"},   32'(evt_ch_o),   32'(ch));
      chk({tag, ".rise"}, 32'(evt_rise_o), 32'(r));
      chk({tag, ".fall"}, 32'(evt_fall_o), 32'(f));
    end
  endtask

  initial begin
    int n;
    int pos;
    logic seen;

    rst = 1'b0; a_i = 4'h0; cfg_rise_en_i = 4'hF; cfg_fall_en_i = 4'hF;
    evt_ready_i = 1'b1; ovf_clr_i = 1'b0;
    tick(); tick();
    chk("rst_valid", 32'(evt_valid_o), 32'h0);
    chk("rst_ch",    32'(evt_ch_o),    32'h0);
    chk("rst_rise",  32'(evt_rise_o),  32'h0);
    chk("rst_fall",  32'(evt_fall_o),  32'h0);
    chk("rst_ovf",   32'(ovf_o),       32'h0);
    rst = 1'b1;
    tick();

    // Simultaneous rises on ch0, ch1, ch3 drain in order from rr_ptr=3
    a_i = 4'hB;
    tick();
    chk_evt("sim_k", 1'b0, 2'd0, 1'b0, 1'b0);
    tick(); chk_evt("sim_e0", 1'b1, 2'd0, 1'b1, 1'b0);
    tick(); chk_evt("sim_e1", 1'b1, 2'd1, 1'b1, 1'b0);
    tick(); chk_evt("sim_e2", 1'b1, 2'd3, 1'b1, 1'b0);
    tick(); chk_evt("sim_idle", 1'b0, 2'd0, 1'b0, 1'b0);

    cfg_fall_en_i = 4'h0; a_i = 4'h0;
    tick(); tick();
    chk_evt("nofall", 1'b0, 2'd0, 1'b0, 1'b0);
    cfg_fall_en_i = 4'hF;

    // Single event on ch2
    a_i = 4'h4;
    tick(); chk_evt("single_k", 1'b0, 2'd0, 1'b0, 1'b0);
    tick(); chk_evt("single_ev", 1'b1, 2'd2, 1'b1, 1'b0);
    tick(); chk_evt("single_idle", 1'b0, 2'd0, 1'b0, 1'b0);
    chk("single_ovf", 32'(ovf_o), 32'h0);

    cfg_fall_en_i = 4'h0; a_i = 4'h0;
    tick(); tick();

    // Backpressure holds the ch1 event stable for 5 cycles
    evt_ready_i = 1'b0; a_i = 4'h2;
    tick(); tick();
    chk_evt("bp_0", 1'b1, 2'd1, 1'b1, 1'b0);
    for (int i = 1; i < 5; i++) begin
      tick();
      chk_evt($sformatf("bp_%0d", i), 1'b1, 2'd1, 1'b1, 1'b0);
    end
    evt_ready_i = 1'b1;
    tick(); chk_evt("bp_done", 1'b0, 2'd0, 1'b0, 1'b0);

    // Overflow: three ch1 rises while the port is blocked
    evt_ready_i = 1'b0;
    a_i = 4'h0; tick();
    a_i = 4'h2; tick();
    a_i = 4'h0; tick();
    chk_evt("ovf_pres", 1'b1, 2'd1, 1'b1, 1'b0);
    a_i = 4'h2; tick();
    chk("ovf_2nd", 32'(ovf_o), 32'h0);
    a_i = 4'h0; tick();
    a_i = 4'h2; tick();
    chk("ovf_3rd", 32'(ovf_o), 32'h2);
    ovf_clr_i = 1'b1; tick(); ovf_clr_i = 1'b0;
    chk("ovf_clr", 32'(ovf_o), 32'h0);
    evt_ready_i = 1'b1;
    tick(); chk_evt("ovf_pend", 1'b1, 2'd1, 1'b1, 1'b0);
    tick(); chk_evt("ovf_idle", 1'b0, 2'd0, 1'b0, 1'b0);
    a_i = 4'h0; tick();

    // Merge: ch3 rise and fall while ch2 occupies the slot
    cfg_fall_en_i = 4'hF; evt_ready_i = 1'b0;
    a_i = 4'h4; tick(); tick();
    chk_evt("mrg_busy", 1'b1, 2'd2, 1'b1, 1'b0);
    a_i = 4'hC; tick();
    a_i = 4'h4; tick();
    evt_ready_i = 1'b1;
    tick(); chk_evt("mrg_ev", 1'b1, 2'd3, 1'b1, 1'b1);
    tick(); chk_evt("mrg_idle", 1'b0, 2'd0, 1'b0, 1'b0);
    cfg_rise_en_i = 4'h7; a_i = 4'hC;
    tick(); tick(); chk_evt("dis_0", 1'b0, 2'd0, 1'b0, 1'b0);
    tick();         chk_evt("dis_1", 1'b0, 2'd0, 1'b0, 1'b0);
    cfg_rise_en_i = 4'hF;

    // Reset with all lines high: no event after release
    rst = 1'b0; a_i = 4'hF;
    tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_evt($sformatf("rel_%0d", i), 1'b0, 2'd0, 1'b0, 1'b0);
    end

    // Fairness: ch0 toggles every cycle, ch2 rises once
    cfg_fall_en_i = 4'h0; a_i = 4'hA;
    tick(); tick();
    cfg_fall_en_i = 4'hF;
    n = 0; pos = 0; seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      a_i[0] = ~a_i[0];
      if (i == 1) a_i[2] = 1'b1;
      tick();
      if (evt_valid_o) begin
        n++;
        if (!seen && evt_ch_o == 2'd2) begin
          seen = 1'b1;
          pos  = n;
        end
      end
    end
    chk("fair_seen", 32'(seen), 32'h1);
    chk("fair_within4", 32'(pos >= 1 && pos <= 4), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
